matmul_sequencer: RTL and testbench

Sequential front end for the combinational `matmat<N>` multiplier. It loads matrices A and B one element per beat over a valid/ready stream and drives the packed operand buses into the multiplier. After a programmable settle window it captures the packed product and streams it out element by element. This turns the deep combinational multiplier into a multicycle path behind a simple streaming interface.

---
 rtl/matmul_seq_pkg.sv | 25 ++
 rtl/matmul_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_pkg.sv
// Shared types and helpers for the matmul_sequencer streaming front end.
package matmul_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  // Number of elements in an N x N matrix.
  function automatic int elem_count(input int n);
    return n * n;
  endfunction

  // Width of an element index for an N x N matrix, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return ($clog2(n * n) < 1) ? 1 : $clog2(n * n);
  endfunction

  localparam int DEFAULT_MATRIX_SIZE = 2;
  localparam int IDX_W = idx_width(DEFAULT_MATRIX_SIZE);

endpackage

// File: rtl/matmul_sequencer.sv
// Streaming sequencer around a combinational N x N matrix multiplier.
// Loads A and B one element per beat, holds them on mat_a/mat_b while the
// external multiplier settles, captures mul into result and streams it out.
// The path mat_a/mat_b -> multiplier -> result_q is a multicycle path of
// SETTLE_CYCLES and must be constrained as such.
module matmul_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MATRIX_SIZE   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              keep_b,
  input  logic [DATA_WIDTH-1:0]                             in_data,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     mat_a,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     mat_b,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     mul,
  output logic [DATA_WIDTH-1:0]                             out_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic                                              out_last,
  output logic                                              busy
);

  localparam int ELEMS = elem_count(MATRIX_SIZE);
  localparam int IW    = idx_width(MATRIX_SIZE);
  localparam int VW    = ELEMS * DATA_WIDTH;
  localparam int CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(ELEMS - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            b_loaded_q, b_loaded_d;
  logic            skip_b_q, skip_b_d;
  logic [VW-1:0]   mat_a_q, mat_a_d;
  logic [VW-1:0]   mat_b_q, mat_b_d;
  logic [VW-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0] res_elem_s;

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      b_loaded_q <= 1'b0;
      skip_b_q   <= 1'b0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      b_loaded_q <= b_loaded_d;
      skip_b_q   <= skip_b_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      result_q   <= result_d;
    end
  end

  // Next-state logic: operand loading, settle countdown and drain indexing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    b_loaded_d = b_loaded_q;
    skip_b_d   = skip_b_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // B may be skipped only if one has actually been loaded since reset.
          skip_b_d = keep_b & b_loaded_q;
          idx_d    = '0;
          state_d  = LOAD_A;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_A: begin
        if (in_valid) begin
          for (int i = 0; i < ELEMS; i++) begin
            if (idx_q == IW'(i)) begin
              mat_a_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end else begin
              mat_a_d[i*DATA_WIDTH +: DATA_WIDTH] = mat_a_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (skip_b_q) begin
              cnt_d   = CNT_INIT;
              state_d = SETTLE;
            end else begin
              state_d = LOAD_B;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = LOAD_A;
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          for (int i = 0; i < ELEMS; i++) begin
            if (idx_q == IW'(i)) begin
              mat_b_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end else begin
              mat_b_d[i*DATA_WIDTH +: DATA_WIDTH] = mat_b_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            b_loaded_d = 1'b1;
            cnt_d      = CNT_INIT;
            state_d    = SETTLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = LOAD_B;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          result_d = mul;
          idx_d    = '0;
          state_d  = DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Select the result element addressed by idx.
  always_comb begin
    res_elem_s = '0;
    for (int i = 0; i < ELEMS; i++) begin
      if (idx_q == IW'(i)) begin
        res_elem_s = result_q[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        res_elem_s = res_elem_s;
      end
    end
  end

  // Outputs decoded from registered state only; no handshake input feeds them.
  always_comb begin
    in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
    mat_a     = mat_a_q;
    mat_b     = mat_b_q;
    if (state_q == DRAIN) begin
      out_data = res_elem_s;
    end else begin
      out_data = '0;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer with a behavioural
// 2x2 multiplier attached (products wrap modulo 256).
module tb_matmul_sequencer;

  localparam int DW = 8;
  localparam int N  = 2;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst, start, keep_b, in_valid, in_ready;
  logic        out_valid, out_ready, out_last, busy;
  logic [7:0]  in_data, out_data;
  logic [31:0] mat_a, mat_b, mul;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int beats = 0;
  int busy_cnt = 0;

  matmul_sequencer #(.DATA_WIDTH(DW), .MATRIX_SIZE(N), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .keep_b(keep_b),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .mul(mul),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference 2x2 multiplier, row-major packing, 8-bit wrap.
  always_comb begin
    logic [7:0] acc, ea, eb;
    mul = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 8'd0;
        for (int k = 0; k < N; k++) begin
          ea  = mat_a[(i*N+k)*8 +: 8];
          eb  = mat_b[(k*N+j)*8 +: 8];
          acc = acc + ea * eb;
        end
        mul[(i*N+j)*8 +: 8] = acc;
      end
    end
  end

  // Cycle counter and accepted-beat counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) beats <= beats + 1;
  end

  // Count busy cycles.
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic keep, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_beats,
                        input int exp_busy, input logic gap, input int stall_elem,
                        input logic pulse);
    logic [63:0] feed;
    logic [7:0]  held;
    logic        acc;
    int          k, budget, lat;
    feed = {b, a};
    @(negedge clk);
    start = 1'b1; keep_b = keep; beats = 0; busy_cnt = 0;
    @(negedge clk);
    start = 1'b0; keep_b = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_ready_rise"}, in_ready, 1'b1);
    k = 0; budget = 0;
    while (k < exp_beats && budget < 64) begin
      in_valid = 1'b1; in_data = feed[k*8 +: 8]; acc = in_ready;
      @(negedge clk); budget++;
      if (acc) begin
        k++;
        if (gap) begin
          in_valid = 1'b0; in_data = 8'h00;
          @(negedge clk);
        end
      end
    end
    check({tag, "_load_beats"}, k, exp_beats);
    // Junk held on the input bus must not be consumed after loading.
    in_valid = 1'b1; in_data = 8'hEE;
    lat = 0;
    while (!out_valid && lat < 32) begin
      @(negedge clk); lat++;
    end
    // lat counts from the cycle after the final beat's cycle.
    if (!gap) check({tag, "_latency"}, lat + 1, SC + 1);
    for (int e = 0; e < 4; e++) begin
      check({tag, "_out_valid"}, out_valid, 1'b1);
      check({tag, "_out_data"}, out_data, exp[e*8 +: 8]);
      check({tag, "_out_last"}, out_last, (e == 3));
      if (e == stall_elem) begin
        out_ready = 1'b0;
        held = exp[e*8 +: 8];
        repeat (3) begin
          @(negedge clk);
          check({tag, "_stall_data"}, out_data, held);
          check({tag, "_stall_valid"}, out_valid, 1'b1);
        end
        out_ready = 1'b1;
      end
      if (pulse && e == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_valid"}, out_valid, 1'b0);
    check({tag, "_beats_total"}, beats, exp_beats);
    check({tag, "_mat_a"}, mat_a, a);
    check({tag, "_mat_b"}, mat_b, b);
    if (exp_busy > 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; keep_b = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_mat_a", mat_a, 32'h0);
    check("rst_mat_b", mat_b, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // keep_b with nothing loaded yet takes the full path.
    run_op("keepb_after_rst", 1'b1, 32'h02000002, 32'h01010101, 32'h02020202, 8, 0, 1'b0, -1, 1'b0);
    // [1,2;3,4] x [5,6;7,8] = [19,22;43,50], 14 busy cycles.
    run_op("basic", 1'b0, 32'h04030201, 32'h08070605, 32'h322B1613, 8, 14, 1'b0, -1, 1'b0);
    // Identity times retained B returns B; only A is loaded.
    run_op("reuse_b", 1'b1, 32'h01000001, 32'h08070605, 32'h08070605, 4, 0, 1'b0, -1, 1'b0);
    // 16*16 + 16*16 = 512 wraps to 0.
    run_op("wrap", 1'b0, 32'h10101010, 32'h10101010, 32'h00000000, 8, 14, 1'b0, -1, 1'b0);
    // Input gaps and a 3-cycle output stall on element 1.
    run_op("backpressure", 1'b0, 32'h04030201, 32'h08070605, 32'h322B1613, 8, 0, 1'b1, 1, 1'b0);

    // Reset in the middle of LOAD_B after one B beat.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrst_loading", in_ready, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_mat_a", mat_a, 32'h0);
    check("midrst_mat_b", mat_b, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // b_loaded cleared, so keep_b still loads B; start pulsed in DRAIN is ignored.
    run_op("rst_then_keep", 1'b1, 32'h04030201, 32'h08070605, 32'h322B1613, 8, 14, 1'b0, -1, 1'b1);
    repeat (2) @(negedge clk);
    check("drain_start_ignored", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
